// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding controller.
package hazard_pkg;

    localparam int unsigned MAX_DEPTH = 6;
    localparam int unsigned MAX_AW    = 8;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        return r;
    endfunction

    // Select width covers RF plus one code per tracked stage at the largest depth.
    localparam int unsigned FWD_W = clog2(MAX_DEPTH + 1);
    localparam logic [FWD_W-1:0] FWD_RF = '0;

    typedef struct packed {
        logic              valid;
        logic              we;
        logic [MAX_AW-1:0] wr;
        logic              is_load;
    } hz_entry_t;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle between the pipeline datapath (master) and the hazard controller (slave).
interface pipe_hazard_ctrl_if
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 32
) ();

    logic              pipe_hold;
    logic              id_valid;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_rs1_used;
    logic              id_rs2_used;
    logic              id_we;
    logic [REG_AW-1:0] id_wr;
    logic              id_is_load;
    logic              ex_redirect;
    logic              stall_if;
    logic              flush_id;
    logic              flush_ex;
    logic [FWD_W-1:0]  fwd_sel1;
    logic [FWD_W-1:0]  fwd_sel2;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    modport master (
        output pipe_hold, id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               id_we, id_wr, id_is_load, ex_redirect,
        input  stall_if, flush_id, flush_ex, fwd_sel1, fwd_sel2, stall_cnt, flush_cnt
    );

    modport slave (
        input  pipe_hold, id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               id_we, id_wr, id_is_load, ex_redirect,
        output stall_if, flush_id, flush_ex, fwd_sel1, fwd_sel2, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/hz_match.sv
// Per-operand scoreboard lookup: youngest producer select and load-use detection.
module hz_match
    import hazard_pkg::*;
#(
    parameter int unsigned DEPTH      = 3,
    parameter int unsigned REG_AW     = 5,
    parameter int unsigned LOAD_READY = 1,
    parameter bit          RF_BYPASS  = 1'b1
) (
    input  hz_entry_t [DEPTH-1:0] sb_i,
    input  logic [REG_AW-1:0]     rs_i,
    input  logic                  rs_used_i,
    output logic [FWD_W-1:0]      fwd_sel_o,
    output logic                  youngest_is_load_idx_o
);

    logic [MAX_AW-1:0] rs_ext;
    logic [DEPTH-1:0]  hit;

    assign rs_ext = MAX_AW'(rs_i);

    always_comb begin
        for (int k = 0; k < int'(DEPTH); k++) begin
            hit[k] = sb_i[k].valid && sb_i[k].we && (sb_i[k].wr != '0) &&
                     (sb_i[k].wr == rs_ext) && rs_used_i;
        end
    end

    // Walk oldest to youngest so the lowest matching index wins.
    always_comb begin
        fwd_sel_o              = FWD_RF;
        youngest_is_load_idx_o = 1'b0;
        for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
            if (hit[k]) begin
                fwd_sel_o = (RF_BYPASS && (k == int'(DEPTH) - 1)) ? FWD_RF : FWD_W'(k + 1);
                youngest_is_load_idx_o = sb_i[k].is_load && (k < int'(LOAD_READY));
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller: destination scoreboard, forwarding selects, load-use stall,
// redirect flush and saturating event counters.
module pipe_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned DEPTH      = 3,   // 2..MAX_DEPTH
    parameter int unsigned REG_AW     = 5,   // up to MAX_AW
    parameter int unsigned LOAD_READY = 1,
    parameter bit          RF_BYPASS  = 1'b1,
    parameter int unsigned CNT_W      = 32
) (
    input logic              cpu_clk,
    input logic              cpu_rst,
    pipe_hazard_ctrl_if.slave hz_if
);

    hz_entry_t [DEPTH-1:0] sb_q, sb_d;
    hz_entry_t             id_entry;
    logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]      flush_cnt_q, flush_cnt_d;
    logic                  lu_rs1, lu_rs2, load_use;
    logic                  stall_ev, flush_ev;

    hz_match #(
        .DEPTH      (DEPTH),
        .REG_AW     (REG_AW),
        .LOAD_READY (LOAD_READY),
        .RF_BYPASS  (RF_BYPASS)
    ) u_match_rs1 (
        .sb_i                   (sb_q),
        .rs_i                   (hz_if.id_rs1),
        .rs_used_i              (hz_if.id_rs1_used),
        .fwd_sel_o              (hz_if.fwd_sel1),
        .youngest_is_load_idx_o (lu_rs1)
    );

    hz_match #(
        .DEPTH      (DEPTH),
        .REG_AW     (REG_AW),
        .LOAD_READY (LOAD_READY),
        .RF_BYPASS  (RF_BYPASS)
    ) u_match_rs2 (
        .sb_i                   (sb_q),
        .rs_i                   (hz_if.id_rs2),
        .rs_used_i              (hz_if.id_rs2_used),
        .fwd_sel_o              (hz_if.fwd_sel2),
        .youngest_is_load_idx_o (lu_rs2)
    );

    assign load_use = lu_rs1 | lu_rs2;

    always_comb begin
        id_entry.valid   = hz_if.id_valid;
        id_entry.we      = hz_if.id_we;
        id_entry.wr      = MAX_AW'(hz_if.id_wr);
        id_entry.is_load = hz_if.id_is_load;

        hz_if.stall_if = 1'b0;
        hz_if.flush_id = 1'b0;
        hz_if.flush_ex = 1'b0;
        stall_ev       = 1'b0;
        flush_ev       = 1'b0;

        // A redirect outranks load-use: the dependent ID instruction is wrong-path.
        if (hz_if.pipe_hold) begin
            hz_if.stall_if = 1'b1;
        end else if (hz_if.ex_redirect) begin
            hz_if.flush_id = 1'b1;
            hz_if.flush_ex = 1'b1;
            flush_ev       = 1'b1;
        end else if (load_use && hz_if.id_valid) begin
            hz_if.stall_if = 1'b1;
            hz_if.flush_ex = 1'b1;
            stall_ev       = 1'b1;
        end

        sb_d        = sb_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!hz_if.pipe_hold) begin
            for (int k = int'(DEPTH) - 1; k > 0; k--) begin
                sb_d[k] = sb_q[k-1];
            end
            sb_d[0] = (stall_ev || flush_ev) ? '0 : id_entry;
            if (stall_ev && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
            if (flush_ev && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge cpu_clk or negedge cpu_rst) begin
        if (!cpu_rst) begin
            sb_q        <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            sb_q        <= sb_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign hz_if.stall_cnt = stall_cnt_q;
    assign hz_if.flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed vector table, corner sequences and random
// stimulus against an instruction-history model, on two parameter sets.
module tb_pipe_hazard_ctrl;

    typedef struct {
        bit hold; bit redir; bit valid;
        int rs1; bit u1; int rs2; bit u2;
        bit we; int wr; bit ld;
    } in_t;

    typedef struct {
        in_t x;
        bit  st; bit fi; bit fe;
        int  s1; int s2; int b1;  // -1 = not checked
    } vec_t;

    typedef struct { bit v; bit we; bit ld; int wr; } ins_t;
    typedef struct { int depth; int lr; bit byp; int cmax; } cfg_t;
    typedef struct { bit stall_if; bit flush_id; bit flush_ex; int sel1; int sel2; bit lu; } exp_t;

    logic clk;
    logic rst_n;

    int   n_vec;
    int   n_bad;
    in_t  cur;
    cfg_t cfg [2];
    ins_t hist [2][8];  // hist[i][d]: instruction that entered EX d advancing cycles ago
    int   msc [2];
    int   mfc [2];
    vec_t tbl [18];

    pipe_hazard_ctrl_if #(.REG_AW(5), .CNT_W(4)) ifa ();
    pipe_hazard_ctrl_if #(.REG_AW(5), .CNT_W(8)) ifb ();

    pipe_hazard_ctrl #(
        .DEPTH(3), .REG_AW(5), .LOAD_READY(1), .RF_BYPASS(1'b1), .CNT_W(4)
    ) u_dut_a (
        .cpu_clk (clk),
        .cpu_rst (rst_n),
        .hz_if   (ifa)
    );

    pipe_hazard_ctrl #(
        .DEPTH(4), .REG_AW(5), .LOAD_READY(2), .RF_BYPASS(1'b0), .CNT_W(8)
    ) u_dut_b (
        .cpu_clk (clk),
        .cpu_rst (rst_n),
        .hz_if   (ifb)
    );

    assign ifb.pipe_hold   = ifa.pipe_hold;
    assign ifb.id_valid    = ifa.id_valid;
    assign ifb.id_rs1      = ifa.id_rs1;
    assign ifb.id_rs2      = ifa.id_rs2;
    assign ifb.id_rs1_used = ifa.id_rs1_used;
    assign ifb.id_rs2_used = ifa.id_rs2_used;
    assign ifb.id_we       = ifa.id_we;
    assign ifb.id_wr       = ifa.id_wr;
    assign ifb.id_is_load  = ifa.id_is_load;
    assign ifb.ex_redirect = ifa.ex_redirect;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic in_t mk(input bit valid, input int rs1, input bit u1, input int rs2,
                               input bit u2, input bit we, input int wr, input bit ld,
                               input bit hold, input bit redir);
        in_t x;
        x.valid = valid; x.rs1 = rs1; x.u1 = u1; x.rs2 = rs2; x.u2 = u2;
        x.we = we; x.wr = wr; x.ld = ld; x.hold = hold; x.redir = redir;
        return x;
    endfunction

    function automatic vec_t mkv(input in_t x, input bit st, input bit fi, input bit fe,
                                 input int s1, input int s2, input int b1);
        vec_t r;
        r.x = x; r.st = st; r.fi = fi; r.fe = fe; r.s1 = s1; r.s2 = s2; r.b1 = b1;
        return r;
    endfunction

    task automatic cmp(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic apply(input in_t x);
        cur = x;
        ifa.pipe_hold   = x.hold;
        ifa.ex_redirect = x.redir;
        ifa.id_valid    = x.valid;
        ifa.id_rs1      = 5'(x.rs1);
        ifa.id_rs2      = 5'(x.rs2);
        ifa.id_rs1_used = x.u1;
        ifa.id_rs2_used = x.u2;
        ifa.id_we       = x.we;
        ifa.id_wr       = 5'(x.wr);
        ifa.id_is_load  = x.ld;
    endtask

    // Nearest in-flight writer of rs decides the select; x0 and unused sources never match.
    function automatic void find(input int i, input int rs, input bit used,
                                 output int sel, output bit lu);
        sel = 0;
        lu  = 1'b0;
        if (!used || rs == 0) return;
        for (int d = 0; d < cfg[i].depth; d++) begin
            if (hist[i][d].v && hist[i][d].we && hist[i][d].wr == rs) begin
                sel = (cfg[i].byp && d == cfg[i].depth - 1) ? 0 : d + 1;
                lu  = hist[i][d].ld && (d < cfg[i].lr);
                return;
            end
        end
    endfunction

    function automatic exp_t predict(input int i);
        exp_t e;
        bit   l1, l2;
        find(i, cur.rs1, cur.u1, e.sel1, l1);
        find(i, cur.rs2, cur.u2, e.sel2, l2);
        e.lu       = l1 || l2;
        e.stall_if = cur.hold || (!cur.redir && e.lu && cur.valid);
        e.flush_id = !cur.hold && cur.redir;
        e.flush_ex = !cur.hold && (cur.redir || (e.lu && cur.valid));
        return e;
    endfunction

    function automatic int sat_inc(input int v, input int m);
        return (v >= m) ? m : v + 1;
    endfunction

    task automatic advance(input int i, input exp_t e);
        ins_t n;
        if (cur.hold) return;
        for (int d = 7; d > 0; d--) hist[i][d] = hist[i][d-1];
        n = '{0, 0, 0, 0};
        if (!e.flush_ex) n = '{cur.valid, cur.we, cur.ld, cur.wr};
        hist[i][0] = n;
        if (cur.redir) mfc[i] = sat_inc(mfc[i], cfg[i].cmax);
        else if (e.lu && cur.valid) msc[i] = sat_inc(msc[i], cfg[i].cmax);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            msc[i] = 0;
            mfc[i] = 0;
            for (int d = 0; d < 8; d++) hist[i][d] = '{0, 0, 0, 0};
        end
    endtask

    task automatic check_dut(input int i, input string tag, input exp_t e);
        int    a [7];
        string t;
        t = $sformatf("%s[%0d]", tag, i);
        if (i == 0) begin
            a = '{int'(ifa.stall_if), int'(ifa.flush_id), int'(ifa.flush_ex),
                  int'(ifa.fwd_sel1), int'(ifa.fwd_sel2), int'(ifa.stall_cnt), int'(ifa.flush_cnt)};
        end else begin
            a = '{int'(ifb.stall_if), int'(ifb.flush_id), int'(ifb.flush_ex),
                  int'(ifb.fwd_sel1), int'(ifb.fwd_sel2), int'(ifb.stall_cnt), int'(ifb.flush_cnt)};
        end
        cmp({t, ".stall_if"}, a[0], int'(e.stall_if));
        cmp({t, ".flush_id"}, a[1], int'(e.flush_id));
        cmp({t, ".flush_ex"}, a[2], int'(e.flush_ex));
        if (!e.lu) begin
            cmp({t, ".fwd_sel1"}, a[3], e.sel1);
            cmp({t, ".fwd_sel2"}, a[4], e.sel2);
        end
        cmp({t, ".stall_cnt"}, a[5], msc[i]);
        cmp({t, ".flush_cnt"}, a[6], mfc[i]);
    endtask

    // Called at posedge+1 with inputs applied; checks at negedge, then crosses one edge.
    task automatic step(input string tag);
        exp_t e [2];
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            e[i] = predict(i);
            check_dut(i, tag, e[i]);
        end
        for (int i = 0; i < 2; i++) advance(i, e[i]);
        @(posedge clk);
        #1;
    endtask

    initial begin
        in_t idle, lw13, add14;
        n_vec = 0;
        n_bad = 0;
        cfg[0] = '{3, 1, 1'b1, 15};
        cfg[1] = '{4, 2, 1'b0, 255};
        model_reset();
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Expected values for the DEPTH=3 / LOAD_READY=1 / RF_BYPASS=1 instance.
        tbl[0]  = mkv(mk(1, 0, 1, 0, 0, 1, 5, 0, 0, 0), 0, 0, 0, 0, 0, -1);   // addi x5
        tbl[1]  = mkv(mk(1, 5, 1, 5, 1, 1, 6, 0, 0, 0), 0, 0, 0, 1, 1, 1);    // add x6,x5,x5
        tbl[2]  = mkv(mk(1, 5, 1, 1, 1, 1, 9, 0, 0, 0), 0, 0, 0, 2, 0, 2);    // distance 2
        tbl[3]  = mkv(mk(1, 5, 1, 0, 1, 1, 10, 0, 0, 0), 0, 0, 0, 0, 0, 3);   // distance 3
        tbl[4]  = mkv(mk(1, 1, 1, 0, 0, 1, 7, 1, 0, 0), 0, 0, 0, 0, 0, -1);   // lw x7
        tbl[5]  = mkv(mk(1, 7, 1, 2, 1, 1, 8, 0, 0, 0), 1, 0, 1, -1, -1, -1); // load-use
        tbl[6]  = mkv(mk(1, 7, 1, 2, 1, 1, 8, 0, 0, 0), 0, 0, 0, 2, 0, -1);
        tbl[7]  = mkv(mk(1, 1, 1, 0, 0, 1, 0, 0, 0, 0), 0, 0, 0, 0, 0, -1);   // write x0
        tbl[8]  = mkv(mk(1, 0, 1, 8, 0, 0, 0, 0, 0, 0), 0, 0, 0, 0, 0, -1);   // read x0, rs2 unused
        tbl[9]  = mkv(mk(1, 1, 1, 0, 0, 1, 3, 1, 0, 0), 0, 0, 0, 0, 0, -1);   // lw x3
        tbl[10] = mkv(mk(1, 3, 1, 3, 1, 1, 4, 0, 0, 1), 0, 1, 1, -1, -1, -1); // redirect + lu
        tbl[11] = mkv(mk(1, 3, 1, 0, 0, 1, 1, 0, 0, 0), 0, 0, 0, 2, 0, -1);
        tbl[12] = mkv(mk(1, 2, 1, 0, 0, 1, 11, 1, 0, 0), 0, 0, 0, 0, 0, -1);  // lw x11
        tbl[13] = mkv(mk(1, 11, 1, 0, 0, 1, 12, 0, 1, 0), 1, 0, 0, -1, -1, -1); // hold x3
        tbl[14] = tbl[13];
        tbl[15] = tbl[13];
        tbl[16] = mkv(mk(1, 11, 1, 0, 0, 1, 12, 0, 0, 0), 1, 0, 1, -1, -1, -1);
        tbl[17] = mkv(mk(1, 11, 1, 0, 0, 1, 12, 0, 0, 0), 0, 0, 0, 2, 0, -1);

        rst_n = 1'b0;
        apply(idle);
        #1;
        cmp("reset.stall_if", int'(ifa.stall_if), 0);
        cmp("reset.flush_ex", int'(ifa.flush_ex), 0);
        cmp("reset.stall_cnt", int'(ifa.stall_cnt), 0);
        cmp("reset.flush_cnt", int'(ifa.flush_cnt), 0);
        #2 rst_n = 1'b1;
        step("idle");

        for (int r = 0; r < 18; r++) begin
            apply(tbl[r].x);
            #1;
            cmp($sformatf("tbl%0d.stall_if", r), int'(ifa.stall_if), int'(tbl[r].st));
            cmp($sformatf("tbl%0d.flush_id", r), int'(ifa.flush_id), int'(tbl[r].fi));
            cmp($sformatf("tbl%0d.flush_ex", r), int'(ifa.flush_ex), int'(tbl[r].fe));
            if (tbl[r].s1 >= 0) cmp($sformatf("tbl%0d.fwd_sel1", r), int'(ifa.fwd_sel1), tbl[r].s1);
            if (tbl[r].s2 >= 0) cmp($sformatf("tbl%0d.fwd_sel2", r), int'(ifa.fwd_sel2), tbl[r].s2);
            if (tbl[r].b1 >= 0) cmp($sformatf("tbl%0d.b.fwd_sel1", r), int'(ifb.fwd_sel1), tbl[r].b1);
            step($sformatf("tbl%0d", r));
        end
        cmp("tbl.end.stall_cnt", int'(ifa.stall_cnt), 2);
        cmp("tbl.end.flush_cnt", int'(ifa.flush_cnt), 1);

        // Asynchronous reset in the middle of a load-use stall.
        lw13  = mk(1, 0, 0, 0, 0, 1, 13, 1, 0, 0);
        add14 = mk(1, 13, 1, 0, 0, 1, 14, 0, 0, 0);
        apply(lw13);
        step("lw13");
        apply(add14);
        #1;
        cmp("mid_stall.pre.stall_if", int'(ifa.stall_if), 1);
        rst_n = 1'b0;
        #1;
        cmp("mid_stall.rst.stall_if_a", int'(ifa.stall_if), 0);
        cmp("mid_stall.rst.stall_if_b", int'(ifb.stall_if), 0);
        cmp("mid_stall.rst.flush_ex", int'(ifa.flush_ex), 0);
        cmp("mid_stall.rst.fwd_sel1", int'(ifa.fwd_sel1), 0);
        cmp("mid_stall.rst.stall_cnt", int'(ifa.stall_cnt), 0);
        cmp("mid_stall.rst.flush_cnt", int'(ifa.flush_cnt), 0);
        model_reset();
        apply(idle);
        rst_n = 1'b1;
        step("post_rst");

        // Drive both counters past the 4-bit ceiling of instance A.
        for (int n = 0; n < 20; n++) begin
            apply(mk(1, 0, 0, 0, 0, 1, 15, 1, 0, 0));
            step("sat.lw");
            apply(mk(1, 15, 1, 0, 0, 1, 16, 0, 0, 0));
            step("sat.use0");
            step("sat.use1");
            apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
            step("sat.redir");
        end
        cmp("sat.stall_cnt", int'(ifa.stall_cnt), 15);
        cmp("sat.flush_cnt", int'(ifa.flush_cnt), 15);

        for (int n = 0; n < 400; n++) begin
            apply(mk($urandom_range(3) != 0, int'($urandom_range(3)), $urandom_range(3) != 0,
                     int'($urandom_range(3)), $urandom_range(3) != 0, $urandom_range(3) != 0,
                     int'($urandom_range(3)), $urandom_range(2) == 0,
                     $urandom_range(7) == 0, $urandom_range(7) == 0));
            step("rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
